// File: rtl/logic_gate_tester.sv
// Stimulus/response checker for a two-input logic_gate block. It walks the four
// {a,b} vectors, samples the 5-bit gate output after a settle time, and scores it.
module logic_gate_tester #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [4:0] o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] err_vec
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  vec_q, vec_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        a_q, a_d, b_q, b_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [2:0]  err_cnt_q, err_cnt_d;
    logic [3:0]  err_vec_q, err_vec_d;
    logic        mism;

    // Expected {AND, OR, XOR, NAND, NOR} for vector index {a,b}.
    function automatic logic [4:0] golden(input logic [1:0] v);
        case (v)
            2'd0:    golden = 5'b00011;
            2'd1:    golden = 5'b01110;
            2'd2:    golden = 5'b01110;
            default: golden = 5'b11000;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_cnt_d = err_cnt_q;
        err_vec_d = err_vec_q;
        mism      = (o != golden(vec_q));
        case (state_q)
            IDLE: begin
                a_d    = 1'b0;
                b_d    = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    pass_d    = 1'b0;
                    err_cnt_d = 3'd0;
                    err_vec_d = 4'd0;
                    vec_d     = 2'd0;
                    cnt_d     = CNT_LOAD;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    if (mism) begin
                        err_vec_d[vec_q] = 1'b1;
                        err_cnt_d        = err_cnt_q + 3'd1;
                    end
                    if (vec_q == 2'd3) begin
                        // Verdict includes the last vector's result sampled on this edge.
                        pass_d  = (err_cnt_d == 3'd0);
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        state_d = DONE;
                    end else begin
                        vec_d      = vec_q + 2'd1;
                        {a_d, b_d} = vec_q + 2'd1;
                        cnt_d      = CNT_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                a_d     = 1'b0;
                b_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            vec_q     <= 2'd0;
            cnt_q     <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= 3'd0;
            err_vec_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_cnt_q <= err_cnt_d;
            err_vec_q <= err_vec_d;
        end
    end

    assign a       = a_q;
    assign b       = b_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_cnt_q;
    assign err_vec = err_vec_q;

endmodule
